// File: rtl/taillamp_pkg.sv
// Shared encodings for the tail-lamp controller: modes, sweep patterns and
// lamp group positions.
package taillamp_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_HAZ   = 2'b11
  } mode_t;

  localparam int LEFT_HI  = 5;
  localparam int LEFT_LO  = 3;
  localparam int RIGHT_HI = 2;
  localparam int RIGHT_LO = 0;

  // Per-phase group patterns, phase 0 in the low slice; both sweep outward
  // from the innermost lamp.
  localparam logic [11:0] LEFT_PATS  = {3'b111, 3'b011, 3'b001, 3'b000};
  localparam logic [11:0] RIGHT_PATS = {3'b111, 3'b110, 3'b100, 3'b000};

  function automatic logic [2:0] left_pat(input logic [1:0] ph);
    return LEFT_PATS[ph*3 +: 3];
  endfunction

  function automatic logic [2:0] right_pat(input logic [1:0] ph);
    return RIGHT_PATS[ph*3 +: 3];
  endfunction

endpackage

// File: rtl/taillamp_ctrl_tick_gen.sv
// Blink-tick divider: TICK is high for the last cycle of every DIV-cycle
// period; clr restarts the period so a new mode gets a full first phase.
module tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/taillamp_ctrl.sv
// Tail-lamp controller: synchronises the switches, arbitrates a lamp mode,
// sequences turn sweeps / hazard flash and overlays the brake lamps.
module taillamp_ctrl
  import taillamp_pkg::*;
#(
  parameter int DIV = 25_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       HAZ,
  input  logic       BRAKE,
  output logic [5:0] lamp,
  output logic [1:0] MODE,
  output logic       TICK,
  output logic [1:0] dbg_phase
);

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic       left_s;
  logic       right_s;
  logic       haz_s;
  logic       brake_s;
  mode_t      mode;
  mode_t      mode_n;
  mode_t      req;
  logic [1:0] phase;
  logic [1:0] phase_n;
  logic       clr;
  logic [5:0] lamp_n;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {LEFT, RIGHT, HAZ, BRAKE};
      sync2 <= sync1;
    end
  end

  assign {left_s, right_s, haz_s, brake_s} = sync2;

  tick_gen #(.DIV(DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (clr),
    .TICK (TICK)
  );

  always_comb begin
    req = MODE_IDLE;
    if (haz_s) begin
      req = MODE_HAZ;
    end else if (left_s && !right_s) begin
      req = MODE_LEFT;
    end else if (right_s && !left_s) begin
      req = MODE_RIGHT;
    end
  end

  // Every mode entry clears the divider; a sweep only ends at phase 0.
  always_comb begin
    mode_n  = mode;
    phase_n = phase;
    clr     = 1'b0;
    case (mode)
      MODE_IDLE: begin
        if (req != MODE_IDLE) begin
          mode_n  = req;
          phase_n = 2'd1;
          clr     = 1'b1;
        end
      end
      MODE_LEFT, MODE_RIGHT: begin
        if (req == MODE_HAZ) begin
          mode_n  = MODE_HAZ;
          phase_n = 2'd1;
          clr     = 1'b1;
        end else if (TICK) begin
          if (phase != 2'd0) begin
            phase_n = phase + 2'd1;
          end else if (req == mode) begin
            phase_n = 2'd1;
          end else if (req == MODE_IDLE) begin
            mode_n  = MODE_IDLE;
            phase_n = 2'd0;
            clr     = 1'b1;
          end else begin
            mode_n  = req;
            phase_n = 2'd1;
            clr     = 1'b1;
          end
        end
      end
      MODE_HAZ: begin
        if (TICK) begin
          if (!haz_s) begin
            mode_n  = MODE_IDLE;
            phase_n = 2'd0;
            clr     = 1'b1;
          end else begin
            phase_n = {1'b0, ~phase[0]};
          end
        end
      end
      default: begin
        mode_n  = MODE_IDLE;
        phase_n = 2'd0;
      end
    endcase
  end

  // Lamps are computed from the next state so they change with MODE.
  always_comb begin
    lamp_n = '0;
    case (mode_n)
      MODE_IDLE: lamp_n = {6{brake_s}};
      MODE_LEFT: begin
        lamp_n[LEFT_HI:LEFT_LO]   = left_pat(phase_n);
        lamp_n[RIGHT_HI:RIGHT_LO] = {3{brake_s}};
      end
      MODE_RIGHT: begin
        lamp_n[LEFT_HI:LEFT_LO]   = {3{brake_s}};
        lamp_n[RIGHT_HI:RIGHT_LO] = right_pat(phase_n);
      end
      MODE_HAZ: lamp_n = {6{phase_n[0]}};
      default:  lamp_n = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode  <= MODE_IDLE;
      phase <= 2'd0;
      lamp  <= '0;
    end else begin
      mode  <= mode_n;
      phase <= phase_n;
      lamp  <= lamp_n;
    end
  end

  assign MODE      = mode;
  assign dbg_phase = phase;

endmodule
